seg_scan_driver: RTL and testbench

Parametrised multiplexed 7-segment display driver: it scans `DIGITS` common-enable digits, and a sequential shift-add-3 converter turns each binary field into a two-digit decimal value. Guard-blank slots sit between digits. It adds a load/busy handshake, an atomic display buffer, overflow dashes, leading-zero blanking and decimal points. It sits between the clock/counter core and the board's digit/segment pins.

---
 rtl/seg_scan_driver.sv | 227 ++++++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver. Binary fields are captured on a load/busy
// handshake, converted serially to two BCD digits each, and committed atomically.
module seg_scan_driver #(
    parameter int FIELDS  = 2,
    parameter int FIELD_W = 6,
    parameter int CLK_DIV = 1024
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [FIELDS*FIELD_W-1:0]   data_show,
    input  logic                        load,
    input  logic                        blank_zero,
    input  logic [2*FIELDS-1:0]         dp_mask,
    output logic                        busy,
    output logic                        overflow,
    output logic [2*FIELDS-1:0]         bytee,
    output logic [6:0]                  segment,
    output logic                        dp
);

    localparam int DIGITS = 2 * FIELDS;
    localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SLOT_W = $clog2(2 * DIGITS);
    localparam int DIG_W  = $clog2(DIGITS);
    localparam int FLD_W  = (FIELDS > 1) ? $clog2(FIELDS) : 1;
    localparam int BIT_W  = $clog2(FIELD_W);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2 * DIGITS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FIELD_W - 1);
    localparam logic [FLD_W-1:0]  FLD_LAST  = FLD_W'(FIELDS - 1);
    localparam logic [3:0]        CODE_DASH = 4'hA;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONV   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    // One double-dabble step: correct both nibbles, then shift the next bit in.
    function automatic logic [7:0] dabble_step(input logic [7:0] acc, input logic bit_in);
        logic [3:0] ones;
        logic [3:0] tens;
        ones = (acc[3:0] >= 4'd5) ? (acc[3:0] + 4'd3) : acc[3:0];
        tens = (acc[7:4] >= 4'd5) ? (acc[7:4] + 4'd3) : acc[7:4];
        return {tens[2:0], ones, bit_in};
    endfunction

    function automatic logic field_over_99(input logic [FIELD_W-1:0] v);
        return ({{(8-FIELD_W){1'b0}}, v} > 8'd99);
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:      s = 7'h3F;
            4'd1:      s = 7'h06;
            4'd2:      s = 7'h5B;
            4'd3:      s = 7'h4F;
            4'd4:      s = 7'h66;
            4'd5:      s = 7'h6D;
            4'd6:      s = 7'h7D;
            4'd7:      s = 7'h07;
            4'd8:      s = 7'h7F;
            4'd9:      s = 7'h6F;
            CODE_DASH: s = 7'h40;
            default:   s = 7'h00;
        endcase
        return s;
    endfunction

    logic [PRE_W-1:0]   r_pre;
    logic [SLOT_W-1:0]  r_slot;
    logic [1:0]         r_state;
    logic               r_busy;
    logic [FLD_W-1:0]   r_fld;
    logic [BIT_W-1:0]   r_bit;
    logic [7:0]         r_acc;
    logic [FIELD_W-1:0] r_shadow [FIELDS];
    logic [7:0]         r_res    [FIELDS];
    logic [7:0]         r_buf    [FIELDS];
    logic [FIELDS-1:0]  r_ovf_pend;
    logic [FIELDS-1:0]  r_buf_ovf;
    logic               r_overflow;
    logic [DIGITS-1:0]  r_bytee;
    logic [6:0]         r_segment;
    logic               r_dp;

    logic [FIELD_W-1:0] w_cur_field;
    logic [7:0]         w_acc_next;
    logic [FIELDS-1:0]  w_ovf_cap;
    logic [DIG_W-1:0]   w_dig;
    logic [SLOT_W-1:0]  w_fld_wide;
    logic [FLD_W-1:0]   w_fld;
    logic               w_tens;
    logic               w_active;
    logic [3:0]         w_nib;
    logic               w_dig_ovf;
    logic [3:0]         w_code;
    logic               w_blank;
    logic [DIGITS-1:0]  w_onehot;

    // Prescaler and scan slot counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pre  <= '0;
            r_slot <= '0;
        end else if (r_pre == PRE_LAST) begin
            r_pre  <= '0;
            r_slot <= (r_slot == SLOT_LAST) ? '0 : (r_slot + SLOT_W'(1));
        end else begin
            r_pre  <= r_pre + PRE_W'(1);
        end
    end

    // Conversion datapath: the current field's MSB feeds the accumulator.
    always_comb begin
        w_cur_field = r_shadow[r_fld];
        w_acc_next  = dabble_step(r_acc, w_cur_field[FIELD_W-1]);
        w_ovf_cap   = '0;
        for (int k = 0; k < FIELDS; k++) begin
            w_ovf_cap[k] = field_over_99(data_show[k*FIELD_W +: FIELD_W]);
        end
    end

    // Capture, serial conversion and atomic commit into the display buffer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_fld      <= '0;
            r_bit      <= '0;
            r_acc      <= 8'd0;
            r_ovf_pend <= '0;
            r_buf_ovf  <= '0;
            for (int k = 0; k < FIELDS; k++) begin
                r_shadow[k] <= '0;
                r_res[k]    <= 8'd0;
                r_buf[k]    <= 8'd0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        for (int k = 0; k < FIELDS; k++) begin
                            r_shadow[k] <= data_show[k*FIELD_W +: FIELD_W];
                        end
                        r_ovf_pend <= w_ovf_cap;
                        r_fld      <= '0;
                        r_bit      <= '0;
                        r_acc      <= 8'd0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_shadow[r_fld] <= {w_cur_field[FIELD_W-2:0], 1'b0};
                    if (r_bit == BIT_LAST) begin
                        r_res[r_fld] <= w_acc_next;
                        r_acc        <= 8'd0;
                        r_bit        <= '0;
                        if (r_fld == FLD_LAST) begin
                            r_state <= ST_COMMIT;
                        end else begin
                            r_fld   <= r_fld + FLD_W'(1);
                        end
                    end else begin
                        r_acc <= w_acc_next;
                        r_bit <= r_bit + BIT_W'(1);
                    end
                end
                ST_COMMIT: begin
                    for (int k = 0; k < FIELDS; k++) begin
                        r_buf[k] <= r_res[k];
                    end
                    r_buf_ovf <= r_ovf_pend;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Slot decode: slot/2 is the digit, slot/4 its field, slot bit 1 selects tens.
    always_comb begin
        w_dig      = r_slot[SLOT_W-1:1];
        w_fld_wide = r_slot >> 2'd2;
        w_fld      = w_fld_wide[FLD_W-1:0];
        w_tens     = r_slot[1];
        w_active   = ~r_slot[0];
        w_nib      = w_tens ? r_buf[w_fld][7:4] : r_buf[w_fld][3:0];
        w_dig_ovf  = r_buf_ovf[w_fld];
        w_code     = w_dig_ovf ? CODE_DASH : w_nib;
        w_blank    = w_tens & blank_zero & (w_nib == 4'd0) & ~w_dig_ovf;
        w_onehot   = {{(DIGITS-1){1'b0}}, 1'b1} << w_dig;
    end

    // Registered pin drivers; guard slots force everything dark.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bytee    <= '0;
            r_segment  <= 7'h00;
            r_dp       <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= (r_state == ST_COMMIT) ? (|r_ovf_pend) : (|r_buf_ovf);
            if (w_active) begin
                r_bytee   <= w_onehot;
                r_segment <= w_blank ? 7'h00 : seg_decode(w_code);
                r_dp      <= dp_mask[w_dig];
            end else begin
                r_bytee   <= '0;
                r_segment <= 7'h00;
                r_dp      <= 1'b0;
            end
        end
    end

    assign busy     = r_busy;
    assign overflow = r_overflow;
    assign bytee    = r_bytee;
    assign segment  = r_segment;
    assign dp       = r_dp;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: instance A (6-bit fields) and instance B
// (7-bit fields, for overflow) share clock, reset, load and display controls.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        blank_zero = 1'b0;
    logic [3:0]  dp_mask = 4'b0000;
    logic [11:0] data_a = 12'd0;
    logic [13:0] data_b = 14'd0;
    logic        busy_a, busy_b, ovf_a, ovf_b, dp_a, dp_b;
    logic [3:0]  bytee_a, bytee_b;
    logic [6:0]  seg_a, seg_b;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [5:0]  f0;
        logic [5:0]  f1;
        logic        bz;
        logic [3:0]  mask;
        logic [27:0] segs;   // {d3,d2,d1,d0}
        logic [3:0]  dps;
    } vec_t;

    vec_t vecs [5];

    seg_scan_driver #(.FIELDS(2), .FIELD_W(6), .CLK_DIV(4)) u_dut_a (
        .clock(clk), .reset(rst), .data_show(data_a), .load(load),
        .blank_zero(blank_zero), .dp_mask(dp_mask), .busy(busy_a),
        .overflow(ovf_a), .bytee(bytee_a), .segment(seg_a), .dp(dp_a)
    );

    seg_scan_driver #(.FIELDS(2), .FIELD_W(7), .CLK_DIV(4)) u_dut_b (
        .clock(clk), .reset(rst), .data_show(data_b), .load(load),
        .blank_zero(blank_zero), .dp_mask(dp_mask), .busy(busy_b),
        .overflow(ovf_b), .bytee(bytee_b), .segment(seg_b), .dp(dp_b)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic do_load(input logic [11:0] da, input logic [13:0] db);
        @(negedge clk);
        data_a = da;
        data_b = db;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100 && (busy_a || busy_b); c++) @(negedge clk);
        check("idle", {30'd0, busy_a, busy_b}, 32'd0);
    endtask

    task automatic read_digit(input bit inst, input int j, output logic [6:0] s, output logic d);
        logic [3:0] want;
        logic [3:0] cur;
        logic       got;
        want = 4'b0001 << j;
        got  = 1'b0;
        cur  = 4'd0;
        for (int c = 0; c < 80 && !got; c++) begin
            @(negedge clk);
            cur = inst ? bytee_b : bytee_a;
            if (cur == want) got = 1'b1;
        end
        check($sformatf("bytee_d%0d", j), 32'(cur), 32'(want));
        s = inst ? seg_b : seg_a;
        d = inst ? dp_b : dp_a;
    endtask

    task automatic check_frame(input bit inst, input logic [27:0] segs, input logic [3:0] dps, input string tag);
        logic [6:0] s;
        logic       d;
        for (int j = 0; j < 4; j++) begin
            read_digit(inst, j, s, d);
            check($sformatf("%s_seg_d%0d", tag, j), 32'(s), 32'(segs[j*7 +: 7]));
            check($sformatf("%s_dp_d%0d", tag, j), 32'(d), 32'(dps[j]));
        end
    endtask

    initial begin
        int cnt_a;
        int cnt_b;
        int slot;
        logic [11:0] exp_scan;

        vecs[0] = '{6'd37, 6'd59, 1'b0, 4'b0000, {7'h6D, 7'h6F, 7'h4F, 7'h07}, 4'b0000};
        vecs[1] = '{6'd5,  6'd0,  1'b1, 4'b0010, {7'h00, 7'h3F, 7'h00, 7'h6D}, 4'b0010};
        vecs[2] = '{6'd0,  6'd63, 1'b0, 4'b1001, {7'h7D, 7'h4F, 7'h3F, 7'h3F}, 4'b1001};
        vecs[3] = '{6'd48, 6'd12, 1'b1, 4'b0000, {7'h06, 7'h5B, 7'h66, 7'h7F}, 4'b0000};
        vecs[4] = '{6'd9,  6'd10, 1'b1, 4'b0101, {7'h06, 7'h3F, 7'h00, 7'h6F}, 4'b0101};

        // Reset: everything dark for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs", {18'd0, bytee_a, seg_a, dp_a, ovf_a, busy_a}, 32'd0);
        end
        rst = 1'b0;

        // Scan order after release: 8 slots of 4 cycles each.
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            slot = c / 4;
            exp_scan = ((slot % 2) == 0) ? {4'(1 << (slot / 2)), 7'h3F, 1'b0} : 12'd0;
            check($sformatf("scan_c%0d", c), {20'd0, bytee_a, seg_a, dp_a}, {20'd0, exp_scan});
        end

        // Busy length: FIELDS*FIELD_W+1 cycles.
        do_load({6'd59, 6'd37}, 14'd0);
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy_a) cnt_a++;
            if (busy_b) cnt_b++;
            @(negedge clk);
        end
        check("busy_len_a", cnt_a, 32'd13);
        check("busy_len_b", cnt_b, 32'd15);

        // Table-driven display vectors.
        for (int v = 0; v < 5; v++) begin
            wait_idle();
            blank_zero = vecs[v].bz;
            dp_mask    = vecs[v].mask;
            do_load({vecs[v].f1, vecs[v].f0}, 14'd0);
            wait_idle();
            check_frame(1'b0, vecs[v].segs, vecs[v].dps, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_ovf", v), 32'(ovf_a), 32'd0);
        end

        // Load while busy is dropped.
        blank_zero = 1'b0;
        dp_mask    = 4'b0000;
        wait_idle();
        do_load({6'd59, 6'd37}, 14'd0);
        repeat (4) @(negedge clk);
        data_a = {6'd22, 6'd11};
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        wait_idle();
        check_frame(1'b0, {7'h6D, 7'h6F, 7'h4F, 7'h07}, 4'b0000, "drop");

        // Load in the first cycle with busy low is accepted.
        do_load({6'd59, 6'd37}, 14'd0);
        for (int c = 0; c < 40 && busy_a; c++) @(negedge clk);
        data_a = {6'd22, 6'd11};
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        check("b2b_accept", 32'(busy_a), 32'd1);
        wait_idle();
        check_frame(1'b0, {7'h5B, 7'h5B, 7'h06, 7'h06}, 4'b0000, "b2b");

        // Overflow on the 7-bit instance.
        blank_zero = 1'b1;
        do_load(12'd0, {7'd100, 7'd42});
        wait_idle();
        check_frame(1'b1, {7'h40, 7'h40, 7'h66, 7'h5B}, 4'b0000, "ovf1");
        check("ovf1_flag_b", 32'(ovf_b), 32'd1);
        check("ovf1_flag_a", 32'(ovf_a), 32'd0);
        do_load(12'd0, {7'd99, 7'd127});
        wait_idle();
        check_frame(1'b1, {7'h6F, 7'h6F, 7'h40, 7'h40}, 4'b0000, "ovf2");
        check("ovf2_flag_b", 32'(ovf_b), 32'd1);
        do_load(12'd0, {7'd7, 7'd99});
        wait_idle();
        check_frame(1'b1, {7'h00, 7'h07, 7'h6F, 7'h6F}, 4'b0000, "ovf3");
        check("ovf3_flag_b", 32'(ovf_b), 32'd0);

        // Reset mid-conversion, with load held during reset.
        blank_zero = 1'b0;
        do_load({6'd12, 6'd48}, {7'd100, 7'd100});
        wait_idle();
        do_load({6'd33, 6'd21}, {7'd120, 7'd120});
        repeat (3) @(negedge clk);
        rst  = 1'b1;
        load = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", {30'd0, busy_a, busy_b}, 32'd0);
        check("rst_mid_first", {20'd0, bytee_a, seg_a, dp_a}, {20'd0, 4'b0001, 7'h3F, 1'b0});
        repeat (20) @(negedge clk);
        check_frame(1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, "rst_a");
        check_frame(1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, "rst_b");
        check("rst_mid_ovf", {30'd0, ovf_a, ovf_b}, 32'd0);
        check("rst_mid_busy_late", {30'd0, busy_a, busy_b}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
